// File: rtl/act_buf_pkg.sv
// ============================================================================
//  Module   : act_buf_pkg
//  Purpose  : Shared types and default sizing for the ping-pong activation
//             buffer (FSM state encoding, default width/depth/address width).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package act_buf_pkg;

  // Control FSM: either accepting producer writes or sweeping zeros into
  // the write bank.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 64;
  localparam int DEF_ADDR_W = 16;

endpackage

`default_nettype wire

// File: rtl/act_buf_bank.sv
// ============================================================================
//  Module   : act_buf_bank
//  Purpose  : One activation bank: DATA_W x DEPTH storage with a single
//             write port and a single registered read port. Storage is not
//             reset; only the read register is.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module act_buf_bank
  import act_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = (DEF_DEPTH > 1) ? $clog2(DEF_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; holds its value when no read is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/act_pingpong_buffer.sv
// ============================================================================
//  Module   : act_pingpong_buffer
//  Purpose  : Double-banked signed activation store between NN layers. The
//             producer writes bank wr_bank while the consumer reads the
//             other bank; swap exchanges them. Includes OOB flagging, a
//             bank-full tracker, and a hardware clear sweep of the write bank.
//  Config   : define ACT_BUF_RELU_EN to ReLU write data before storage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module act_pingpong_buffer
  import act_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_oob,
  input  logic              swap,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              wr_full,
  output logic              err_sticky,
  output logic              wr_bank
);

  localparam int                AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
  localparam logic [AW-1:0]     LAST_ADDR = AW'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [AW-1:0]     sweep_cnt;
  logic [DEPTH-1:0]  written;
  logic              rd_sel;
  logic              rd_oob_hold;

  logic              idle;
  logic              sweeping;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              wr_accept;
  logic              wr_drop;
  logic              do_swap;
  logic              do_clear;
  logic [DATA_W-1:0] store_data;
  logic [AW-1:0]     bank_waddr;
  logic [DATA_W-1:0] bank_wdata;
  logic [DATA_W-1:0] bank_rdata [2];

  assign idle        = (state == ST_IDLE);
  assign sweeping    = (state == ST_CLEAR);
  assign wr_in_range = (wr_addr < DEPTH_A);
  assign rd_in_range = (rd_addr < DEPTH_A);
  assign wr_accept   = wr_en && wr_in_range && idle;
  assign wr_drop     = wr_en && !(wr_in_range && idle);
  assign do_swap     = swap && idle;
  assign do_clear    = clear_start && idle;

`ifdef ACT_BUF_RELU_EN
  // Negative activations are clamped to zero on the way in.
  assign store_data = wr_data[DATA_W-1] ? '0 : wr_data;
`else
  assign store_data = wr_data;
`endif

  // The sweep owns the write port while it runs; producer writes are dropped.
  assign bank_waddr = sweeping ? sweep_cnt : wr_addr[AW-1:0];
  assign bank_wdata = sweeping ? '0 : store_data;

  // Next-state logic: one full pass over the write bank per clear request.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (clear_start) state_nxt = ST_CLEAR;
      ST_CLEAR: if (sweep_cnt == LAST_ADDR) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Sweep address: starts at 0 on entry, advances one entry per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_cnt <= '0;
    end else if (sweeping && sweep_cnt != LAST_ADDR) begin
      sweep_cnt <= sweep_cnt + 1'b1;
    end else begin
      sweep_cnt <= '0;
    end
  end

  // Bank select and sticky drop error. A same-cycle write has already been
  // steered to the old bank, so toggling here is safe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (do_swap) wr_bank    <= ~wr_bank;
      if (wr_drop) err_sticky <= 1'b1;
    end
  end

  // Written bitmap for the current write bank; a fresh bank (swap) or a
  // bank about to be zeroed (clear) starts empty, overriding a same-cycle write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      written <= '0;
    end else if (do_swap || do_clear) begin
      written <= '0;
    end else if (wr_accept) begin
      written[wr_addr[AW-1:0]] <= 1'b1;
    end
  end

  assign wr_full    = &written;
  assign clear_busy = sweeping;

  // Read-side bookkeeping: which bank the pending data came from and
  // whether it was an out-of-range request (forced to zero).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid    <= 1'b0;
      rd_sel      <= 1'b0;
      rd_oob_hold <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_sel      <= ~wr_bank;
        rd_oob_hold <= !rd_in_range;
      end
    end
  end

  assign rd_data = rd_oob_hold ? '0 : bank_rdata[rd_sel];
  assign rd_oob  = rd_valid && rd_oob_hold;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic BIDX = 1'(b);
    logic bank_we;
    logic bank_re;

    assign bank_we = (wr_bank == BIDX) && (sweeping || wr_accept);
    assign bank_re = (wr_bank != BIDX) && rd_en && rd_in_range;

    act_buf_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (bank_we),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .re    (bank_re),
      .raddr (rd_addr[AW-1:0]),
      .rdata (bank_rdata[b])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_act_pingpong_buffer.sv
// ============================================================================
//  Module   : tb_act_pingpong_buffer
//  Purpose  : Directed, table-driven bench for act_pingpong_buffer with
//             hand-written sequences for clear sweep, swap and reset corners.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_act_pingpong_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_oob;
  logic        swap = 1'b0;
  logic        clear_start = 1'b0;
  logic        clear_busy;
  logic        wr_full;
  logic        err_sticky;
  logic        wr_bank;

  int ncmp = 0;
  int nerr = 0;

`ifdef ACT_BUF_RELU_EN
  localparam logic [31:0] NEG7_STORED = 32'h0000_0000;
`else
  localparam logic [31:0] NEG7_STORED = 32'hFFFF_FFF9;
`endif

  act_pingpong_buffer #(
    .DATA_W (32),
    .DEPTH  (64),
    .ADDR_W (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_oob      (rd_oob),
    .swap        (swap),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .wr_full     (wr_full),
    .err_sticky  (err_sticky),
    .wr_bank     (wr_bank)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic        exp_valid;
    logic        exp_oob;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mkv(input string nm, input logic we, input logic [15:0] wa,
                               input logic [31:0] wd, input logic re, input logic [15:0] ra,
                               input logic ev, input logic eo, input logic [31:0] ed,
                               input logic ee);
    vec_t v;
    v.name = nm; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.rd_en = re; v.rd_addr = ra; v.exp_valid = ev; v.exp_oob = eo;
    v.exp_data = ed; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string nm, input logic [15:0] a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk1({nm, "_valid"}, rd_valid, 1'b1);
    chk32(nm, rd_data, exp);
  endtask

  // Pulse clear_start (swap may be pre-set by the caller), then count busy
  // cycles; optionally issue a write at busy cycle 'inject'.
  task automatic run_clear(input string nm, input int inject);
    int n;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    swap = 1'b0;
    chk1({nm, "_busy_rise"}, clear_busy, 1'b1);
    n = 1;
    while (n < 200) begin
      if (n == inject) begin
        wr_en = 1'b1; wr_addr = 16'd9; wr_data = 32'h99;
      end
      tick();
      wr_en = 1'b0;
      if (!clear_busy) break;
      n++;
    end
    chk32({nm, "_busy_cycles"}, 32'(n), 32'd64);
  endtask

  initial begin
    vecs[0] = mkv("rd5",        1'b0, 16'd0,  32'd0,   1'b1, 16'd5,      1'b1, 1'b0, 32'd15,  1'b0);
    vecs[1] = mkv("idle_hold",  1'b0, 16'd0,  32'd0,   1'b0, 16'd0,      1'b0, 1'b0, 32'd15,  1'b0);
    vecs[2] = mkv("rd63",       1'b0, 16'd0,  32'd0,   1'b1, 16'd63,     1'b1, 1'b0, 32'd189, 1'b0);
    vecs[3] = mkv("wr70_rd0",   1'b1, 16'd70, 32'd123, 1'b1, 16'd0,      1'b1, 1'b0, 32'd0,   1'b1);
    vecs[4] = mkv("rd64_oob",   1'b0, 16'd0,  32'd0,   1'b1, 16'd64,     1'b1, 1'b1, 32'd0,   1'b1);
    vecs[5] = mkv("rdffff_oob", 1'b0, 16'd0,  32'd0,   1'b1, 16'hFFFF,   1'b1, 1'b1, 32'd0,   1'b1);
    vecs[6] = mkv("oob_hold",   1'b0, 16'd0,  32'd0,   1'b0, 16'd0,      1'b0, 1'b0, 32'd0,   1'b1);
    vecs[7] = mkv("wrneg_rd62", 1'b1, 16'd2,  32'hFFFF_FFF9, 1'b1, 16'd62, 1'b1, 1'b0, 32'd186, 1'b1);

    // Reset state
    tick();
    tick();
    chk32("rst_rd_data", rd_data, 32'd0);
    chk1("rst_rd_valid", rd_valid, 1'b0);
    chk1("rst_rd_oob", rd_oob, 1'b0);
    chk1("rst_clear_busy", clear_busy, 1'b0);
    chk1("rst_wr_full", wr_full, 1'b0);
    chk1("rst_err", err_sticky, 1'b0);
    chk1("rst_wr_bank", wr_bank, 1'b0);
    rst = 1'b0;

    // Zero bank 0, then swap+clear together zeros bank 1 (the new write bank)
    run_clear("clr0", 0);
    swap = 1'b1;
    run_clear("swapclr1", 0);
    chk1("swapclr_bank", wr_bank, 1'b1);
    swap = 1'b1;
    tick();
    swap = 1'b0;
    chk1("back_to_bank0", wr_bank, 1'b0);

    // Fill bank 0 with addr*3 and track the full flag
    for (int a = 0; a < 64; a++) begin
      wr_en = 1'b1; wr_addr = 16'(a); wr_data = 32'(a * 3);
      tick();
      if (a == 62) chk1("full_before_last", wr_full, 1'b0);
      if (a == 63) chk1("full_after_last", wr_full, 1'b1);
    end
    wr_addr = 16'd0; wr_data = 32'd0;
    tick();
    wr_en = 1'b0;
    chk1("full_after_rewrite", wr_full, 1'b1);
    swap = 1'b1;
    tick();
    swap = 1'b0;
    chk1("swap1_bank", wr_bank, 1'b1);
    chk1("swap1_full_cleared", wr_full, 1'b0);

    // Table: reads of bank 0, OOB write/read, negative write into bank 1
    for (int i = 0; i < 8; i++) begin
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      chk1({vecs[i].name, "_valid"}, rd_valid, vecs[i].exp_valid);
      chk1({vecs[i].name, "_oob"}, rd_oob, vecs[i].exp_oob);
      chk32({vecs[i].name, "_data"}, rd_data, vecs[i].exp_data);
      chk1({vecs[i].name, "_err"}, err_sticky, vecs[i].exp_err);
    end

    // Swap: bank 1 becomes readable; dropped write to 70 must not alias to 6
    swap = 1'b1;
    tick();
    swap = 1'b0;
    chk1("swap2_bank", wr_bank, 1'b0);
    read_chk("relu_rd2", 16'd2, NEG7_STORED);
    read_chk("oob_noalias_rd6", 16'd6, 32'd0);

    // Swap with same-cycle write (old write bank) and read (old read bank)
    swap = 1'b1; wr_en = 1'b1; wr_addr = 16'd9; wr_data = 32'h55;
    rd_en = 1'b1; rd_addr = 16'd2;
    tick();
    swap = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk1("swap3_bank", wr_bank, 1'b1);
    chk32("swap_cycle_read_old", rd_data, NEG7_STORED);
    read_chk("swap_write_rd9", 16'd9, 32'h55);
    read_chk("bank0_rd10", 16'd10, 32'd30);

    // Reset, then clear with a write attempted mid-sweep
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("rst2_bank", wr_bank, 1'b0);
    chk1("rst2_err", err_sticky, 1'b0);
    run_clear("clr_inject", 3);
    chk1("clr_drop_err", err_sticky, 1'b1);
    chk1("clr_full", wr_full, 1'b0);
    swap = 1'b1;
    tick();
    swap = 1'b0;
    read_chk("cleared_rd5", 16'd5, 32'd0);
    read_chk("cleared_rd9", 16'd9, 32'd0);

    // Reset mid-sweep acts immediately
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    rd_en = 1'b1; rd_addr = 16'd1;
    tick();
    rd_en = 1'b0;
    chk1("pre_rst_busy", clear_busy, 1'b1);
    chk1("pre_rst_valid", rd_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("async_rst_busy", clear_busy, 1'b0);
    chk1("async_rst_bank", wr_bank, 1'b0);
    chk1("async_rst_valid", rd_valid, 1'b0);
    chk32("async_rst_data", rd_data, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

`default_nettype wire
